// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide data memory port between two cache
// controllers (0 = instruction cache, 1 = data cache). It grants one requester
// at a time, latches that request and holds it on the memory port until the
// memory acknowledges. The acknowledge is then routed back to the granted
// requester only. Simultaneous requests are resolved round-robin, and
// requester 0 wins the first tie after reset.
//
// Optional feature: define MEM_ARB_STATS_EN to build saturating grant and wait
// counters. Without the macro, the stat_* outputs are tied to zero.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int STAT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic [LINE_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [STAT_W-1:0] stat_grant0_o,
  output logic [STAT_W-1:0] stat_grant1_o,
  output logic [STAT_W-1:0] stat_wait_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q;
  logic              grant_q;
  logic              last_q;
  logic              mem_enable_q;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [LINE_W-1:0] req_data_q;

  logic              any_req_d;
  logic              grant_d;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req_d = m0_enable_i | m1_enable_i;
    grant_d   = 1'b0;
    if (m0_enable_i && m1_enable_i) begin
      grant_d = ~last_q;
    end else if (m1_enable_i) begin
      grant_d = 1'b1;
    end else begin
      grant_d = 1'b0;
    end
  end

  // Transaction FSM: latch the winner's request in IDLE, hold it until the memory acks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      mem_enable_q <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= {ADDR_W{1'b0}};
      req_data_q   <= {LINE_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            grant_q      <= grant_d;
            req_write_q  <= grant_d ? m1_write_i : m0_write_i;
            req_addr_q   <= grant_d ? m1_addr_i  : m0_addr_i;
            req_data_q   <= grant_d ? m1_data_i  : m0_data_i;
            mem_enable_q <= 1'b1;
            state_q      <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            last_q       <= grant_q;
            mem_enable_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q <= BUSY;
          end
        end
        default: begin
          mem_enable_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // The memory port is driven straight from the latched request registers.
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = req_write_q;
  assign mem_addr_o   = req_addr_q;
  assign mem_data_o   = req_data_q;

  // Read data goes to both ports; only the matching ack qualifies it.
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;
  assign m0_ack_o  = (state_q == BUSY) & mem_ack_i & ~grant_q;
  assign m1_ack_o  = (state_q == BUSY) & mem_ack_i &  grant_q;

`ifdef MEM_ARB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] stat_grant0_q;
  logic [STAT_W-1:0] stat_grant1_q;
  logic [STAT_W-1:0] stat_wait_q;
  logic              grant_ev_d;
  logic              wait_ev_d;

  // Event decode: a grant happens on the IDLE->BUSY step; waiting means the other requester is held off.
  always_comb begin
    grant_ev_d = (state_q == IDLE) & any_req_d;
    wait_ev_d  = 1'b0;
    if (state_q == BUSY) begin
      wait_ev_d = grant_q ? m0_enable_i : m1_enable_i;
    end else begin
      wait_ev_d = 1'b0;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_grant0_q <= {STAT_W{1'b0}};
      stat_grant1_q <= {STAT_W{1'b0}};
      stat_wait_q   <= {STAT_W{1'b0}};
    end else begin
      if (grant_ev_d && !grant_d && (stat_grant0_q != STAT_MAX)) begin
        stat_grant0_q <= stat_grant0_q + STAT_ONE;
      end
      if (grant_ev_d && grant_d && (stat_grant1_q != STAT_MAX)) begin
        stat_grant1_q <= stat_grant1_q + STAT_ONE;
      end
      if (wait_ev_d && (stat_wait_q != STAT_MAX)) begin
        stat_wait_q <= stat_wait_q + STAT_ONE;
      end
    end
  end

  assign stat_grant0_o = stat_grant0_q;
  assign stat_grant1_o = stat_grant1_q;
  assign stat_wait_o   = stat_wait_q;
`else
  assign stat_grant0_o = {STAT_W{1'b0}};
  assign stat_grant1_o = {STAT_W{1'b0}};
  assign stat_wait_o   = {STAT_W{1'b0}};
`endif

endmodule
